// File: rtl/alu_ex_stage_if.sv
// Handshake bus for the ALU execute stage: decode-side request channel and
// writeback-side result channel.
interface alu_ex_stage_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      alu_control;
    logic [XLEN-1:0] in_a;
    logic [XLEN-1:0] in_b;
    logic [4:0]      in_rd;

    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_result;
    logic            out_zero;
    logic            out_illegal;
    logic [4:0]      out_rd;

    modport master (
        output in_valid, alu_control, in_a, in_b, in_rd, out_ready,
        input  in_ready, out_valid, out_result, out_zero, out_illegal, out_rd
    );

    modport slave (
        input  in_valid, alu_control, in_a, in_b, in_rd, out_ready,
        output in_ready, out_valid, out_result, out_zero, out_illegal, out_rd
    );
endinterface

// File: rtl/alu_ex_stage.sv
// ALU execute stage: combinational compute feeding a small in-order result
// FIFO so writeback stalls only reach decode once the buffer is full.
module alu_ex_compute #(
    parameter int XLEN = 32
) (
    input  logic [3:0]      alu_control,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] result,
    output logic            illegal
);
    always_comb begin
        result  = '0;
        illegal = 1'b0;
        case (alu_control)
            4'b0010: result = a + b;
            4'b0110: result = a - b;
            4'b0000: result = a & b;
            4'b0001: result = a | b;
            4'b0111: result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            default: illegal = 1'b1;
        endcase
    end
endmodule

module alu_ex_stage #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           flush,
    alu_ex_stage_if.slave  bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [XLEN-1:0] result;
        logic            zero;
        logic            illegal;
        logic [4:0]      rd;
    } entry_t;

    entry_t          mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;

    logic [XLEN-1:0] alu_result;
    logic            alu_illegal;
    entry_t          new_entry;
    entry_t          head;
    logic            accept;
    logic            pop;

    alu_ex_compute #(.XLEN(XLEN)) u_compute (
        .alu_control (bus.alu_control),
        .a           (bus.in_a),
        .b           (bus.in_b),
        .result      (alu_result),
        .illegal     (alu_illegal)
    );

    always_comb begin
        new_entry.result  = alu_result;
        new_entry.zero    = (alu_result == '0);
        new_entry.illegal = alu_illegal;
        new_entry.rd      = bus.in_rd;
    end

    // in_ready depends only on local state, never on out_ready, so a pop
    // into a full buffer frees the slot from the following cycle.
    assign bus.in_ready  = !rst && !flush && (count < CW'(DEPTH));
    assign bus.out_valid = !rst && (count != '0);
    assign accept        = bus.in_valid && bus.in_ready;
    assign pop           = bus.out_valid && bus.out_ready;

    assign head            = bus.out_valid ? mem[rd_ptr] : '0;
    assign bus.out_result  = head.result;
    assign bus.out_zero    = head.zero;
    assign bus.out_illegal = head.illegal;
    assign bus.out_rd      = head.rd;

    always_ff @(posedge clk) begin
        if (rst) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (accept) begin
                mem[wr_ptr] <= new_entry;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            case ({accept, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule
